// File: rtl/wide_add_sequencer.sv
// Multi-cycle W = M*N bit adder built from one M-bit carry-skip adder.
// Chunks are processed LSB first, with the carry held in a register between chunks.

module carry_skip_adder #(
  parameter int m = 4
) (
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  input  logic         cin,
  output logic [m-1:0] sum,
  output logic         cout,
  output logic         prop_all
);

  logic [m-1:0] p;
  logic [m-1:0] g;
  logic         c;

  // NOTE: every output of an always_comb is assigned before any branch can skip it,
  // so no latch can be inferred; the blocking '=' chains c from bit to bit.
  always_comb begin
    p        = a ^ b;
    g        = a & b;
    c        = cin;
    sum      = '0;
    for (int i = 0; i < m; i++) begin
      sum[i] = p[i] ^ c;
      c      = g[i] | (p[i] & c);
    end
    prop_all = &p;
    // When every bit propagates, cin bypasses the ripple chain.
    cout     = prop_all ? cin : c;
  end

endmodule

module wide_add_sequencer #(
  parameter int M = 4,
  parameter int N = 4,
  localparam int W  = M * N,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  sum,
  output logic          cout,
  output logic [CW-1:0] skip_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q,     state_d;
  logic [W-1:0]  a_q,         a_d;
  logic [W-1:0]  b_q,         b_d;
  logic          carry_q,     carry_d;
  logic [IW-1:0] idx_q,       idx_d;
  logic [W-1:0]  sum_q,       sum_d;
  logic          cout_q,      cout_d;
  logic [CW-1:0] skip_cnt_q,  skip_cnt_d;
  logic          in_ready_q,  in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [M-1:0]  chunk_a;
  logic [M-1:0]  chunk_b;
  logic [M-1:0]  chunk_sum;
  logic          chunk_cout;
  logic          chunk_skip;

  assign chunk_a = a_q[int'(idx_q) * M +: M];
  assign chunk_b = b_q[int'(idx_q) * M +: M];

  carry_skip_adder #(.m(M)) u_adder (
    .a        (chunk_a),
    .b        (chunk_b),
    .cin      (carry_q),
    .sum      (chunk_sum),
    .cout     (chunk_cout),
    .prop_all (chunk_skip)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    skip_cnt_d  = skip_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone marks an accept.
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          idx_d      = '0;
          sum_d      = '0;
          skip_cnt_d = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        sum_d[int'(idx_q) * M +: M] = chunk_sum;
        carry_d = chunk_cout;
        if (chunk_skip) begin
          skip_cnt_d = skip_cnt_q + CW'(1);
        end
        if (idx_q == IW'(N - 1)) begin
          cout_d      = chunk_cout;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      skip_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      skip_cnt_q  <= skip_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: operand registers are deliberately left without reset; they are always
  // reloaded on accept before being read, so a reset would only add routing.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign skip_cnt  = skip_cnt_q;

endmodule
